pbs_damage_datapath: RTL and testbench
======================================

Name: pbs_damage_datapath

Overview:
- Battle datapath driven by the turn-control FSM.
- Latches the player's move during move-load and holds both Pokemon HP registers.
- On each one-cycle apply_damage strobe, computes damage over a short multi-cycle sequence, then applies it with saturation to the selected target.
- Returns HP values and faint flags to the control FSM and the display.

Parameters:
- HP_W, 4: width of each HP register.
- MAX_HP, 15: HP value loaded at reset, for both Pokemon.
- P_ATK, 3: player Pokemon attack stat.
- P_DEF, 2: player Pokemon defence stat.
- AI_ATK, 2: AI Pokemon attack stat.
- AI_DEF, 1: AI Pokemon defence stat.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- load_pm  in  1  high while the control FSM is in the move-load state; move_sel is sampled every cycle it is high
- move_sel  in  2  player move index
- apply_damage  in  1  single-cycle strobe starting one damage computation
- active_trainer  in  1  attacker: 0 = player, 1 = AI
- target  in  1  victim: 0 = player Pokemon, 1 = AI Pokemon
- p_hp  out  HP_W  player Pokemon HP
- ai_hp  out  HP_W  AI Pokemon HP
- p_fainted  out  1  p_hp == 0
- ai_fainted  out  1  ai_hp == 0
- last_damage  out  HP_W  damage applied by the most recent completed attack
- busy  out  1  computation in progress
- done  out  1  one-cycle pulse when the HP update is visible

Behaviour:
- Reset (asynchronous, reset_n low):
  - p_hp = ai_hp = MAX_HP; last_damage = 0.
  - busy = done = 0; state = IDLE; player move register = 0; AI move counter = 0.
  - Reset asserted mid-computation aborts the computation; no HP update is applied.
- Move power table, fixed: index 0 -> 1, 1 -> 2, 2 -> 3, 3 -> 4.
- Player move register: loads move_sel on every clk edge while load_pm = 1; holds otherwise.
- AI move: 2-bit counter. The current value is used for an AI attack, and the counter increments (wrap 3 -> 0) when that attack's done pulses.
- State machine (IDLE, CALC, APPLY, DONE):
  - IDLE -> CALC when apply_damage = 1. Latch active_trainer and target. busy goes high the cycle after the strobe.
  - CALC, 1 cycle: raw = power(move of attacker) + atk(attacker) − def(target's Pokemon), computed signed in HP_W+3 bits. dmg = clamp(raw, 1, 2^HP_W − 1).
  - APPLY, 1 cycle: target HP <= HP − dmg if HP > dmg, else 0. last_damage <= dmg.
  - DONE, 1 cycle: done = 1, busy = 0. Next state is IDLE.
- Latency: strobe sampled at edge N; HP register updates at edge N+2; done is high during the cycle after edge N+3.
- Boundary and special cases:
  - apply_damage while busy or in DONE: ignored, no queueing.
  - target == active_trainer: legal self-hit. Attacker stats and target defence are used as normal.
  - Target already at 0: stays 0. done still pulses; last_damage still updates.
  - Faint flags are combinational from the HP registers.
  - HP never increases except through reset.
- load_pm during a computation: allowed. CALC uses the player move register value present in the CALC cycle.

Optional Feature:
- Macro: PBS_CRIT_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 at reset) advances every clk.
  - In CALC, if LFSR[2:0] == 3'b000, raw is doubled before clamping.
  - Extra output port crit (1 bit) is high together with done when the attack was critical.
- Undefined:
  - No LFSR and no crit port.
  - Damage is always the un-doubled value.

Test Plan:
- Reset release -> p_hp = 15, ai_hp = 15, both faint flags 0, busy = 0, done = 0.
- load_pm with move_sel = 3, then apply_damage, active_trainer = 0, target = 1 -> dmg = 4+3−1 = 6; ai_hp = 9 at edge N+2; done pulses once after edge N+3; last_damage = 6.
- AI attack with counter 0 (active_trainer = 1, target = 0) -> dmg = 1+2−2 = 1; p_hp = 14. Second AI attack uses power 2 -> dmg 2; p_hp = 12.
- Repeat player move 3 on AI from ai_hp = 3 -> ai_hp saturates to 0; ai_fainted = 1. A further attack leaves it at 0 with done pulsing.
- apply_damage re-asserted during CALC and APPLY -> ignored: exactly one HP change and one done pulse. reset_n low during APPLY -> HP returns to 15 immediately and no done.
- PBS_CRIT_EN: force LFSR[2:0] = 0 at CALC with player move 3 -> dmg = 12 and crit = 1 with done. Otherwise dmg = 6 and crit = 0.

Source files
------------

// File: rtl/pbs_damage_datapath.sv
// Battle damage datapath: latches the player move, holds both HP registers, and applies clamped damage.
// Optional critical hits (LFSR-driven damage doubling plus a crit output) are built when PBS_CRIT_EN is defined.
module pbs_damage_datapath #(
   parameter int HP_W   = 4,
   parameter int MAX_HP = 15,
   parameter int P_ATK  = 3,
   parameter int P_DEF  = 2,
   parameter int AI_ATK = 2,
   parameter int AI_DEF = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load_pm,
   input  logic [1:0]      move_sel,
   input  logic            apply_damage,
   input  logic            active_trainer,
   input  logic            target,
   output logic [HP_W-1:0] p_hp,
   output logic [HP_W-1:0] ai_hp,
   output logic            p_fainted,
   output logic            ai_fainted,
   output logic [HP_W-1:0] last_damage,
   output logic            busy,
   output logic            done
`ifdef PBS_CRIT_EN
   ,
   output logic            crit
`endif
);

   localparam int RW = HP_W + 3;
   localparam logic signed [RW-1:0] DMG_MIN_S = RW'(1);
   localparam logic signed [RW-1:0] DMG_MAX_S = RW'((1 << HP_W) - 1);

   typedef enum logic [1:0] {IDLE, CALC, APPLY, DONE} state_t;

   state_t                 state_r, state_s;
   logic [1:0]             pm_r;
   logic [1:0]             ai_mv_r;
   logic                   att_r;
   logic                   tgt_r;
   logic [HP_W-1:0]        dmg_r;
   logic [HP_W-1:0]        p_hp_r;
   logic [HP_W-1:0]        ai_hp_r;
   logic [HP_W-1:0]        last_damage_r;
   logic                   busy_r;
   logic                   done_r;
   logic [1:0]             mv_s;
   logic signed [RW-1:0]   raw_s;
   logic signed [RW-1:0]   eff_s;
   logic [HP_W-1:0]        dmg_s;
   logic                   crit_s;

   // HP minus damage, floored at zero
   function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp, input logic [HP_W-1:0] dmg);
      if (hp > dmg) begin
         sat_sub = hp - dmg;
      end else begin
         sat_sub = {HP_W{1'b0}};
      end
   endfunction

`ifdef PBS_CRIT_EN
   logic [7:0] lfsr_r;
   logic       crit_pend_r;
   logic       crit_r;

   // Free-running Fibonacci LFSR, taps 8,6,5,4
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_r <= 8'hA5;
      end else begin
         lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
      end
   end

   assign crit_s = (lfsr_r[2:0] == 3'b000);
   assign crit   = crit_r;
`else
   assign crit_s = 1'b0;
`endif

   // Damage for the latched attacker/target; evaluated during CALC
   always_comb begin
      mv_s  = att_r ? ai_mv_r : pm_r;
      raw_s = RW'(mv_s) + RW'(1)
            + (att_r ? RW'(AI_ATK) : RW'(P_ATK))
            - (tgt_r ? RW'(AI_DEF) : RW'(P_DEF));
      if (crit_s) begin
         eff_s = raw_s <<< 1;
      end else begin
         eff_s = raw_s;
      end
      if (eff_s < DMG_MIN_S) begin
         dmg_s = HP_W'(1);
      end else if (eff_s > DMG_MAX_S) begin
         dmg_s = DMG_MAX_S[HP_W-1:0];
      end else begin
         dmg_s = eff_s[HP_W-1:0];
      end
   end

   // Next-state logic; strobes outside IDLE are dropped
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (apply_damage) begin
               state_s = CALC;
            end else begin
               state_s = IDLE;
            end
         end
         CALC:    state_s = APPLY;
         APPLY:   state_s = DONE;
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath registers sequenced by the state machine
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pm_r          <= 2'd0;
         ai_mv_r       <= 2'd0;
         att_r         <= 1'b0;
         tgt_r         <= 1'b0;
         dmg_r         <= {HP_W{1'b0}};
         p_hp_r        <= HP_W'(MAX_HP);
         ai_hp_r       <= HP_W'(MAX_HP);
         last_damage_r <= {HP_W{1'b0}};
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
`ifdef PBS_CRIT_EN
         crit_pend_r   <= 1'b0;
         crit_r        <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
`ifdef PBS_CRIT_EN
         crit_r <= 1'b0;
`endif
         if (load_pm) begin
            pm_r <= move_sel;
         end
         case (state_r)
            IDLE: begin
               if (apply_damage) begin
                  att_r  <= active_trainer;
                  tgt_r  <= target;
                  busy_r <= 1'b1;
               end
            end
            CALC: begin
               dmg_r <= dmg_s;
`ifdef PBS_CRIT_EN
               crit_pend_r <= crit_s;
`endif
            end
            APPLY: begin
               last_damage_r <= dmg_r;
               if (tgt_r) begin
                  ai_hp_r <= sat_sub(ai_hp_r, dmg_r);
               end else begin
                  p_hp_r <= sat_sub(p_hp_r, dmg_r);
               end
            end
            DONE: begin
               done_r <= 1'b1;
               busy_r <= 1'b0;
`ifdef PBS_CRIT_EN
               crit_r <= crit_pend_r;
`endif
               if (att_r) begin
                  ai_mv_r <= ai_mv_r + 2'd1;
               end
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign p_hp        = p_hp_r;
   assign ai_hp       = ai_hp_r;
   assign last_damage = last_damage_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign p_fainted   = (p_hp_r == {HP_W{1'b0}});
   assign ai_fainted  = (ai_hp_r == {HP_W{1'b0}});

endmodule

// File: tb/tb_pbs_damage_datapath.sv
// Randomized self-checking bench for pbs_damage_datapath against a cycle-by-cycle reference of the battle rules.
module tb_pbs_damage_datapath;

   localparam int P_ATK = 3, P_DEF = 2, AI_ATK = 2, AI_DEF = 1, MAX_HP = 15;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       load_pm = 1'b0;
   logic [1:0] move_sel = 2'd0;
   logic       apply_damage = 1'b0;
   logic       active_trainer = 1'b0;
   logic       target = 1'b0;
   logic [3:0] p_hp, ai_hp, last_damage;
   logic       p_fainted, ai_fainted, busy, done;
`ifdef PBS_CRIT_EN
   logic       crit;
   logic [7:0] lfsr_m;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // reference state
   int p_hp_m, ai_hp_m, last_m, pm_m, ai_cnt_m;

   pbs_damage_datapath dut (
      .clk(clk), .reset_n(reset_n), .load_pm(load_pm), .move_sel(move_sel),
      .apply_damage(apply_damage), .active_trainer(active_trainer), .target(target),
      .p_hp(p_hp), .ai_hp(ai_hp), .p_fainted(p_fainted), .ai_fainted(ai_fainted),
      .last_damage(last_damage), .busy(busy), .done(done)
`ifdef PBS_CRIT_EN
      , .crit(crit)
`endif
   );

   always #5 clk = ~clk;

`ifdef PBS_CRIT_EN
   // Reference random sequence: seed A5, shift left, feedback from bits 8,6,5,4
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) lfsr_m <= 8'hA5;
      else          lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
   end
`endif

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_hp(input string tag);
      check_eq({tag, "_p_hp"}, 32'(p_hp), 32'(p_hp_m));
      check_eq({tag, "_ai_hp"}, 32'(ai_hp), 32'(ai_hp_m));
      check_eq({tag, "_p_faint"}, 32'(p_fainted), 32'(p_hp_m == 0));
      check_eq({tag, "_ai_faint"}, 32'(ai_fainted), 32'(ai_hp_m == 0));
   endtask

   function automatic void model_reset();
      p_hp_m = MAX_HP; ai_hp_m = MAX_HP; last_m = 0; pm_m = 0; ai_cnt_m = 0;
   endfunction

   // Called 1 time unit after a posedge; returns 1 time unit after a later posedge
   task automatic do_reset();
      reset_n = 1'b0;
      apply_damage = 1'b0;
      load_pm = 1'b0;
      #2;
      model_reset();
      check_hp("rst");
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_last", 32'(last_damage), 32'd0);
      #2 reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic load_move(input logic [1:0] sel);
      load_pm = 1'b1; move_sel = sel;
      @(posedge clk); #1;
      load_pm = 1'b0; pm_m = int'(sel);
   endtask

   task automatic attack(input logic att, input logic tgt, input bit spur, input bit ld_mid,
                         input logic [1:0] ld_sel);
      int raw, dmg, mv;
      bit crit_m;
      apply_damage = 1'b1; active_trainer = att; target = tgt;
      @(posedge clk); #1;
      mv  = att ? ai_cnt_m : pm_m;
      raw = (mv + 1) + (att ? AI_ATK : P_ATK) - (tgt ? AI_DEF : P_DEF);
      crit_m = 1'b0;
`ifdef PBS_CRIT_EN
      crit_m = (lfsr_m[2:0] == 3'b000);
      if (crit_m) raw = raw * 2;
`endif
      dmg = (raw < 1) ? 1 : ((raw > 15) ? 15 : raw);
      apply_damage = spur;
      active_trainer = 1'($urandom_range(0, 1));
      target = 1'($urandom_range(0, 1));
      if (ld_mid) begin load_pm = 1'b1; move_sel = ld_sel; end
      check_eq("calc_busy", 32'(busy), 32'd1);
      check_eq("calc_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      if (ld_mid) begin load_pm = 1'b0; pm_m = int'(ld_sel); end
      check_hp("apply");
      @(posedge clk); #1;
      if (tgt) ai_hp_m = (ai_hp_m > dmg) ? ai_hp_m - dmg : 0;
      else     p_hp_m  = (p_hp_m > dmg) ? p_hp_m - dmg : 0;
      last_m = dmg;
      check_hp("upd");
      check_eq("upd_last", 32'(last_damage), 32'(last_m));
      check_eq("upd_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      apply_damage = 1'b0;
      check_eq("done_pulse", 32'(done), 32'd1);
      check_eq("done_busy", 32'(busy), 32'd0);
`ifdef PBS_CRIT_EN
      check_eq("done_crit", 32'(crit), 32'(crit_m));
`endif
      if (att) ai_cnt_m = (ai_cnt_m + 1) % 4;
      @(posedge clk); #1;
      check_eq("post_done", 32'(done), 32'd0);
      check_hp("post");
   endtask

   initial begin
      model_reset();
      @(posedge clk); #1;
      do_reset();

      load_move(2'd3);
      attack(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
`ifndef PBS_CRIT_EN
      check_eq("first_ai_hp", 32'(ai_hp), 32'd9);
      check_eq("first_last", 32'(last_damage), 32'd6);
`endif
      attack(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
      attack(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
`ifndef PBS_CRIT_EN
      check_eq("ai2_p_hp", 32'(p_hp), 32'd12);
`endif
      repeat (3) attack(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
      check_eq("ai_dead", 32'(ai_fainted), 32'd1);
      attack(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      attack(1'b0, 1'b1, 1'b0, 1'b1, 2'd1);

      // abort in APPLY
      apply_damage = 1'b1; active_trainer = 1'b0; target = 1'b0;
      @(posedge clk); #1;
      apply_damage = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #2;
      model_reset();
      check_hp("abort");
      check_eq("abort_busy", 32'(busy), 32'd0);
      #2 reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_eq("abort_nodone", 32'(done), 32'd0);
      end
      check_hp("abort_after");

      for (int k = 0; k < 60; k++) begin
         if ((p_hp_m == 0 && ai_hp_m == 0) || $urandom_range(0, 19) == 0) do_reset();
         if ($urandom_range(0, 2) == 0) load_move(2'($urandom_range(0, 3)));
         attack(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
